// File: rtl/fifo_usb_drain_if.sv
// fifo_usb_drain_if: sample-FIFO read side, FT245 write side and status of the USB drain.
//   master: the environment (FIFO, USB bridge, control); slave: the drain itself.
//   en, fifo_dout, fifo_empty, ft_txe_n -> drain; fifo_rd, ft_wr_n, ft_data, busy,
//   words_sent, stall_cnt <- drain. test_mode exists only with USB_DRAIN_TEST_PATTERN_EN.
interface fifo_usb_drain_if #(parameter int STALL_W = 16);
    logic               en;
    logic [15:0]        fifo_dout;
    logic               fifo_empty;
    logic               fifo_rd;
    logic               ft_txe_n;
    logic               ft_wr_n;
    logic [7:0]         ft_data;
    logic               busy;
    logic [31:0]        words_sent;
    logic [STALL_W-1:0] stall_cnt;
`ifdef USB_DRAIN_TEST_PATTERN_EN
    logic               test_mode;
    modport master (output en, fifo_dout, fifo_empty, ft_txe_n, test_mode,
                    input fifo_rd, ft_wr_n, ft_data, busy, words_sent, stall_cnt);
    modport slave  (input en, fifo_dout, fifo_empty, ft_txe_n, test_mode,
                    output fifo_rd, ft_wr_n, ft_data, busy, words_sent, stall_cnt);
`else
    modport master (output en, fifo_dout, fifo_empty, ft_txe_n,
                    input fifo_rd, ft_wr_n, ft_data, busy, words_sent, stall_cnt);
    modport slave  (input en, fifo_dout, fifo_empty, ft_txe_n,
                    output fifo_rd, ft_wr_n, ft_data, busy, words_sent, stall_cnt);
`endif
endinterface

// File: rtl/fifo_usb_drain.sv
// fifo_usb_drain: pops 16-bit words from the sample FIFO and streams them as bytes
// into an FT245-style synchronous USB write port, one byte per clock when ready.
//   fifo_clk, reset (sync, active high); bus: fifo_usb_drain_if.slave.
//   Optional macro USB_DRAIN_TEST_PATTERN_EN adds test_mode and an internal counter source.
module fifo_usb_drain #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int STALL_W   = 16
) (
    input logic            fifo_clk,
    input logic            reset,
    fifo_usb_drain_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND_B0, SEND_B1} state_t;
    state_t             state_q, state_d;
    logic [15:0]        word_q, word_d, src;
    logic [7:0]         data_q, data_d;
    logic [31:0]        sent_q, sent_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               pending, accept, avail, pop;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return LSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return LSB_FIRST ? w[15:8] : w[7:0];
    endfunction

`ifdef USB_DRAIN_TEST_PATTERN_EN
    logic [15:0] pat_q, pat_d;
    // The pattern source is always available, so the FIFO flag and strobe are bypassed.
    assign avail       = bus.test_mode | ~bus.fifo_empty;
    assign src         = bus.test_mode ? pat_q : bus.fifo_dout;
    assign bus.fifo_rd = pop & ~bus.test_mode;
    assign pat_d       = (pop & bus.test_mode) ? pat_q + 16'd1 : pat_q;
    always_ff @(posedge fifo_clk) pat_q <= reset ? '0 : pat_d;
`else
    assign avail       = ~bus.fifo_empty;
    assign src         = bus.fifo_dout;
    assign bus.fifo_rd = pop;
`endif

    assign pending = state_q != IDLE;
    assign accept  = pending & ~bus.ft_txe_n;
    // Loading in SEND_B1 on the last byte's acceptance keeps the stream bubble-free.
    assign pop     = bus.en & avail & (state_q == IDLE | (state_q == SEND_B1 & accept));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        sent_d  = sent_q + 32'(state_q == SEND_B1 && accept);
        stall_d = (pending & bus.ft_txe_n & ~&stall_q) ? stall_q + STALL_W'(1) : stall_q;
        if (pop) begin
            state_d = SEND_B0;
            word_d  = src;
            data_d  = first_byte(src);
        end else if (accept) begin
            state_d = state_q == SEND_B0 ? SEND_B1 : IDLE;
            data_d  = state_q == SEND_B0 ? second_byte(word_q) : data_q;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            data_q  <= '0;
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign bus.ft_wr_n    = ~accept;
    assign bus.ft_data    = data_q;
    assign bus.busy       = pending;
    assign bus.words_sent = sent_q;
    assign bus.stall_cnt  = stall_q;
endmodule
